cnt_seq_monitor: RTL and testbench

//  Receive-side checker for the free-running CNT_W-bit count bus a counter block drives.

---
 rtl/cnt_seq_monitor_pkg.sv | 21 ++
 rtl/cnt_seq_monitor_sat_cnt.sv | 31 +++
 rtl/cnt_seq_monitor.sv | 180 ++++++++++++++++++
 tb/tb_cnt_seq_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_monitor_pkg.sv
// Shared types for the count-sequence monitor: FSM state encodings and sample classification.
package cnt_seq_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMP_GOOD = 2'd0,
    CMP_HOLD = 2'd1,
    CMP_BAD  = 2'd2
  } cmp_t;

  localparam int DEF_CNT_W    = 4;
  localparam int DEF_CNT_MAX  = 15;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_ERR_W    = 8;

endpackage

// File: rtl/cnt_seq_monitor_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment on the clear edge leaves it at 1.
module cnt_seq_sat_cnt
  import cnt_seq_monitor_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [ERR_W-1:0] o_cnt
);

  logic [ERR_W-1:0] r_cnt;
  logic             w_full;

  assign w_full = (r_cnt == {ERR_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? ERR_W'(1) : '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + ERR_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cnt_seq_monitor.sv
// Receive-side checker for a free-running 0..CNT_MAX count bus: locks, flags breaks and wraps.
// Optional first-error capture ports are enabled with CNT_SEQ_MONITOR_ERR_LOG_EN.
module cnt_seq_monitor
  import cnt_seq_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CNT_MAX  = DEF_CNT_MAX,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] exp_cnt
`ifdef CNT_SEQ_MONITOR_ERR_LOG_EN
  ,
  output logic [CNT_W-1:0] err_exp,
  output logic [CNT_W-1:0] err_act,
  output logic             err_log_vld
`endif
);

  localparam int               RUN_W    = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W:0]   MAX_EXT  = (CNT_W + 1)'(CNT_MAX);

  function automatic logic [CNT_W-1:0] next_of(input logic [CNT_W-1:0] v);
    return (v == MAX_V) ? '0 : v + CNT_W'(1);
  endfunction

  state_t           r_state, w_state_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt;
  logic [CNT_W-1:0] r_cnt_q;
  logic [CNT_W-1:0] r_exp_cnt;
  logic             r_err_pulse;
  logic             r_wrap_pulse;
  logic             r_sticky;

  logic [CNT_W-1:0] w_expected;
  logic             w_in_range;
  cmp_t             w_cmp;
  logic             w_err;
  logic             w_wrap;
  logic [ERR_W-1:0] w_err_cnt;

  assign w_expected = next_of(r_cnt_q);
  // Values above CNT_MAX are never legal, even if they repeat or follow a bad value.
  assign w_in_range = ({1'b0, cnt_in} <= MAX_EXT);

  always_comb begin
    w_cmp = CMP_BAD;
    if (w_in_range && (cnt_in == w_expected)) begin
      w_cmp = CMP_GOOD;
    end else if (w_in_range && (cnt_in == r_cnt_q)) begin
      w_cmp = CMP_HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // First sample only seeds cnt_q; there is nothing to compare against yet.
        w_state_nxt = ST_ACQ;
        w_run_nxt   = '0;
      end
      ST_ACQ: begin
        if (w_cmp == CMP_GOOD) begin
          if ((r_run + RUN_W'(1)) == LOCK_RUN) begin
            w_state_nxt = ST_LOCKED;
            w_run_nxt   = '0;
          end else begin
            w_run_nxt = r_run + RUN_W'(1);
          end
        end else if (w_cmp == CMP_BAD) begin
          w_run_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (w_cmp == CMP_BAD) begin
          w_err       = 1'b1;
          w_state_nxt = ST_ACQ;
          w_run_nxt   = '0;
        end else if ((w_cmp == CMP_GOOD) && (r_cnt_q == MAX_V)) begin
          w_wrap = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_q      <= '0;
      r_exp_cnt    <= '0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_sticky     <= 1'b0;
    end else begin
      r_cnt_q      <= cnt_in;
      r_exp_cnt    <= next_of(cnt_in);
      r_err_pulse  <= w_err;
      r_wrap_pulse <= w_wrap;
      // A new error on the clear edge must stay visible.
      if (w_err) begin
        r_sticky <= 1'b1;
      end else if (clr) begin
        r_sticky <= 1'b0;
      end
    end
  end

  cnt_seq_sat_cnt #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_err),
    .i_clr (clr),
    .o_cnt (w_err_cnt)
  );

`ifdef CNT_SEQ_MONITOR_ERR_LOG_EN
  logic [CNT_W-1:0] r_log_exp;
  logic [CNT_W-1:0] r_log_act;
  logic             r_log_vld;

  // Only the first error after rst/clr is kept; clr on the same edge re-arms and captures it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_log_exp <= '0;
      r_log_act <= '0;
      r_log_vld <= 1'b0;
    end else if (w_err && (!r_log_vld || clr)) begin
      r_log_exp <= w_expected;
      r_log_act <= cnt_in;
      r_log_vld <= 1'b1;
    end else if (clr) begin
      r_log_exp <= '0;
      r_log_act <= '0;
      r_log_vld <= 1'b0;
    end
  end

  assign err_exp     = r_log_exp;
  assign err_act     = r_log_act;
  assign err_log_vld = r_log_vld;
`endif

  assign locked     = (r_state == ST_LOCKED);
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_sticky;
  assign err_cnt    = w_err_cnt;
  assign wrap_pulse = r_wrap_pulse;
  assign exp_cnt    = r_exp_cnt;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Bench for cnt_seq_monitor: default instance plus a CNT_MAX=12 instance; covers the
// optional CNT_SEQ_MONITOR_ERR_LOG_EN ports when that macro is defined.
module tb_cnt_seq_monitor;

  typedef struct {
    logic [3:0] cnt;
    logic       clr;
    logic       lk;
    logic       ep;
    logic       wp;
    logic [7:0] ec;
    logic       st;
    logic [3:0] ex;
    logic       lv;
    logic [3:0] le;
    logic [3:0] la;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, clr2;
  logic [3:0] cnt_in, cnt_in2;

  logic       locked, err_pulse, err_sticky, wrap_pulse;
  logic [7:0] err_cnt;
  logic [3:0] exp_cnt;
  logic       locked2, err_pulse2, err_sticky2, wrap_pulse2;
  logic [7:0] err_cnt2;
  logic [3:0] exp_cnt2;
`ifdef CNT_SEQ_MONITOR_ERR_LOG_EN
  logic [3:0] err_exp, err_act, err_exp2, err_act2;
  logic       err_log_vld, err_log_vld2;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t tbl[21];

  always #10 clk = ~clk;

  cnt_seq_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .wrap_pulse (wrap_pulse),
    .exp_cnt    (exp_cnt)
`ifdef CNT_SEQ_MONITOR_ERR_LOG_EN
    ,
    .err_exp     (err_exp),
    .err_act     (err_act),
    .err_log_vld (err_log_vld)
`endif
  );

  cnt_seq_monitor #(
    .CNT_W    (4),
    .CNT_MAX  (12),
    .LOCK_CNT (4),
    .ERR_W    (8)
  ) dut12 (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in2),
    .clr        (clr2),
    .locked     (locked2),
    .err_pulse  (err_pulse2),
    .err_sticky (err_sticky2),
    .err_cnt    (err_cnt2),
    .wrap_pulse (wrap_pulse2),
    .exp_cnt    (exp_cnt2)
`ifdef CNT_SEQ_MONITOR_ERR_LOG_EN
    ,
    .err_exp     (err_exp2),
    .err_act     (err_act2),
    .err_log_vld (err_log_vld2)
`endif
  );

  function automatic vec_t mk(input logic [3:0] c, input logic cl, input logic lk,
                              input logic ep, input logic wp, input logic [7:0] ec,
                              input logic st, input logic [3:0] ex, input logic lv,
                              input logic [3:0] le, input logic [3:0] la);
    vec_t v;
    v.cnt = c;  v.clr = cl; v.lk = lk; v.ep = ep; v.wp = wp; v.ec = ec;
    v.st  = st; v.ex  = ex; v.lv = lv; v.le = le; v.la = la;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic cl);
    cnt_in = c;
    clr    = cl;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic drive2(input logic [3:0] c);
    cnt_in2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    sb.push_back(v);
    drive(v.cnt, v.clr);
    e = sb.pop_front();
    check($sformatf("v%0d locked", idx), 32'(locked), 32'(e.lk));
    check($sformatf("v%0d err_pulse", idx), 32'(err_pulse), 32'(e.ep));
    check($sformatf("v%0d wrap_pulse", idx), 32'(wrap_pulse), 32'(e.wp));
    check($sformatf("v%0d err_cnt", idx), 32'(err_cnt), 32'(e.ec));
    check($sformatf("v%0d err_sticky", idx), 32'(err_sticky), 32'(e.st));
    check($sformatf("v%0d exp_cnt", idx), 32'(exp_cnt), 32'(e.ex));
`ifdef CNT_SEQ_MONITOR_ERR_LOG_EN
    check($sformatf("v%0d err_log_vld", idx), 32'(err_log_vld), 32'(e.lv));
    check($sformatf("v%0d err_exp", idx), 32'(err_exp), 32'(e.le));
    check($sformatf("v%0d err_act", idx), 32'(err_act), 32'(e.la));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int         m;

    //            cnt  clr lk ep wp ec st ex  lv le la
    tbl[0]  = mk(4'd0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0);
    tbl[1]  = mk(4'd1,  0, 0, 0, 0, 0, 0, 2,  0, 0, 0);
    tbl[2]  = mk(4'd2,  0, 0, 0, 0, 0, 0, 3,  0, 0, 0);
    tbl[3]  = mk(4'd3,  0, 0, 0, 0, 0, 0, 4,  0, 0, 0);
    tbl[4]  = mk(4'd4,  0, 1, 0, 0, 0, 0, 5,  0, 0, 0);
    tbl[5]  = mk(4'd5,  0, 1, 0, 0, 0, 0, 6,  0, 0, 0);
    tbl[6]  = mk(4'd7,  0, 0, 1, 0, 1, 1, 8,  1, 6, 7);
    tbl[7]  = mk(4'd8,  0, 0, 0, 0, 1, 1, 9,  1, 6, 7);
    tbl[8]  = mk(4'd9,  0, 0, 0, 0, 1, 1, 10, 1, 6, 7);
    tbl[9]  = mk(4'd10, 0, 0, 0, 0, 1, 1, 11, 1, 6, 7);
    tbl[10] = mk(4'd11, 0, 1, 0, 0, 1, 1, 12, 1, 6, 7);
    tbl[11] = mk(4'd12, 0, 1, 0, 0, 1, 1, 13, 1, 6, 7);
    tbl[12] = mk(4'd13, 0, 1, 0, 0, 1, 1, 14, 1, 6, 7);
    tbl[13] = mk(4'd14, 0, 1, 0, 0, 1, 1, 15, 1, 6, 7);
    tbl[14] = mk(4'd15, 0, 1, 0, 0, 1, 1, 0,  1, 6, 7);
    tbl[15] = mk(4'd0,  0, 1, 0, 1, 1, 1, 1,  1, 6, 7);
    tbl[16] = mk(4'd1,  0, 1, 0, 0, 1, 1, 2,  1, 6, 7);
    tbl[17] = mk(4'd1,  0, 1, 0, 0, 1, 1, 2,  1, 6, 7);
    tbl[18] = mk(4'd2,  0, 1, 0, 0, 1, 1, 3,  1, 6, 7);
    tbl[19] = mk(4'd3,  1, 1, 0, 0, 0, 0, 4,  0, 0, 0);
    tbl[20] = mk(4'd9,  1, 0, 1, 0, 1, 1, 10, 1, 4, 9);

    rst = 1'b1; clr = 1'b0; clr2 = 1'b0; cnt_in = 4'd5; cnt_in2 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst locked", 32'(locked), 0);
    check("rst err_pulse", 32'(err_pulse), 0);
    check("rst err_sticky", 32'(err_sticky), 0);
    check("rst err_cnt", 32'(err_cnt), 0);
    check("rst wrap_pulse", 32'(wrap_pulse), 0);
    check("rst exp_cnt", 32'(exp_cnt), 0);
    check("rst locked12", 32'(locked2), 0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) apply(i, tbl[i]);

    // 300 forced errors, each preceded by a relock
    v = 4'd9;
    m = 1;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) begin
        v = v + 4'd1;
        drive(v, 1'b0);
      end
      check($sformatf("relock%0d", i), 32'(locked), 1);
      v = v + 4'd3;
      drive(v, 1'b0);
      m = (m < 255) ? m + 1 : 255;
      check($sformatf("burst err_pulse%0d", i), 32'(err_pulse), 1);
      check($sformatf("burst err_cnt%0d", i), 32'(err_cnt), 32'(m));
    end
    check("sat err_cnt", 32'(err_cnt), 255);

    drive(v, 1'b1);
    check("clr err_cnt", 32'(err_cnt), 0);
    check("clr err_sticky", 32'(err_sticky), 0);
    check("clr err_pulse", 32'(err_pulse), 0);
`ifdef CNT_SEQ_MONITOR_ERR_LOG_EN
    check("clr err_log_vld", 32'(err_log_vld), 0);
`endif
    for (int k = 0; k < 4; k++) begin
      v = v + 4'd1;
      drive(v, 1'b0);
    end
    v = v + 4'd3;
    drive(v, 1'b1);
    check("clr+err err_cnt", 32'(err_cnt), 1);
    check("clr+err err_sticky", 32'(err_sticky), 1);
    check("clr+err err_pulse", 32'(err_pulse), 1);

    // asynchronous reset while locked
    for (int k = 0; k < 4; k++) begin
      v = v + 4'd1;
      drive(v, 1'b0);
    end
    check("pre-rst locked", 32'(locked), 1);
    #4;
    rst = 1'b1;
    #1;
    check("async rst locked", 32'(locked), 0);
    check("async rst err_sticky", 32'(err_sticky), 0);
    check("async rst err_cnt", 32'(err_cnt), 0);
    check("async rst exp_cnt", 32'(exp_cnt), 0);
    check("async rst err_pulse", 32'(err_pulse), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'd0, 1'b0);
    check("post-rst first sample locked", 32'(locked), 0);
    check("post-rst exp_cnt", 32'(exp_cnt), 1);
    drive(4'd1, 1'b0);
    drive(4'd2, 1'b0);
    drive(4'd3, 1'b0);
    check("post-rst run3 locked", 32'(locked), 0);
    drive(4'd4, 1'b0);
    check("post-rst relock", 32'(locked), 1);

    // CNT_MAX=12 instance: hold, wrap at 12, out-of-range value
    cnt_in = 4'd4;
    for (int c = 1; c <= 4; c++) drive2(4'(c));
    check("m12 locked", 32'(locked2), 1);
    drive2(4'd5);
    drive2(4'd6);
    drive2(4'd6);
    check("m12 hold err_pulse", 32'(err_pulse2), 0);
    check("m12 hold locked", 32'(locked2), 1);
    check("m12 hold exp_cnt", 32'(exp_cnt2), 7);
    for (int c = 7; c <= 12; c++) drive2(4'(c));
    check("m12 exp after max", 32'(exp_cnt2), 0);
    drive2(4'd0);
    check("m12 wrap_pulse", 32'(wrap_pulse2), 1);
    check("m12 wrap err_pulse", 32'(err_pulse2), 0);
    drive2(4'd1);
    check("m12 wrap_pulse drop", 32'(wrap_pulse2), 0);
    drive2(4'd15);
    check("m12 >max err_pulse", 32'(err_pulse2), 1);
    check("m12 >max locked", 32'(locked2), 0);
    check("m12 >max err_cnt", 32'(err_cnt2), 1);
    check("m12 >max wrap_pulse", 32'(wrap_pulse2), 0);
    check("m12 main unaffected", 32'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
